// File: rtl/ps2_host_tx_if.sv
// Command/status bundle between a command source and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       rx_inhibit;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  busy,
        input  rx_inhibit,
        input  done,
        input  ack_ok,
        input  err_timeout
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output busy,
        output rx_inhibit,
        output done,
        output ack_ok,
        output err_timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, start, 8 data bits LSB first,
// odd parity, stop, then samples the device ACK. Pads are open-drain, so the
// outputs are pull-low enables; 0 always means "release the line".
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         clk,
    input  logic         clrn,
    ps2_host_tx_if.slave bus,
    input  logic         i_ps2_clk,
    input  logic         i_ps2_data,
    output logic         o_ps2_clk_oe,
    output logic         o_ps2_data_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_START = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic [1:0]       r_clkSync;
    logic [1:0]       r_dataSync;
    logic             r_clkPrev;
    logic [7:0]       r_data;
    logic             r_parity;
    logic [3:0]       r_bitCnt;
    logic [INH_W-1:0] r_inhCnt;
    logic [TO_W-1:0]  r_toCnt;
    logic             r_clkOe;
    logic             r_dataOe;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             r_ackOk;
    logic             r_errTo;
    logic             r_ackNext;

    logic w_fall;
    logic w_clkHigh;
    logic w_dataHigh;
    logic w_accept;
    logic w_timedOut;

    assign w_clkHigh  = r_clkSync[1];
    assign w_dataHigh = r_dataSync[1];
    assign w_fall     = r_clkPrev & ~r_clkSync[1];
    assign w_accept   = bus.tx_valid & r_ready;
    assign w_timedOut = (r_toCnt == TO_LIMIT);

    // Two-flop synchronisers on both pads plus a delayed clock sample for edge detection.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
            r_clkPrev  <= 1'b1;
        end else begin
            r_clkSync  <= {r_clkSync[0], i_ps2_clk};
            r_dataSync <= {r_dataSync[0], i_ps2_data};
            r_clkPrev  <= r_clkSync[1];
        end
    end

    // Frame sequencer; every output is a register so the pads never glitch.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= IDLE;
            r_data    <= 8'h00;
            r_parity  <= 1'b0;
            r_bitCnt  <= 4'd0;
            r_inhCnt  <= '0;
            r_toCnt   <= '0;
            r_clkOe   <= 1'b0;
            r_dataOe  <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ackOk   <= 1'b0;
            r_errTo   <= 1'b0;
            r_ackNext <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_errTo <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready  <= 1'b1;
                    r_clkOe  <= 1'b0;
                    r_dataOe <= 1'b0;
                    if (w_accept) begin
                        r_data   <= bus.tx_data;
                        r_parity <= ~^bus.tx_data;
                        r_bitCnt <= 4'd0;
                        r_inhCnt <= '0;
                        r_toCnt  <= '0;
                        r_ackOk  <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_clkOe  <= 1'b1;
                        r_state  <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    r_inhCnt <= r_inhCnt + INH_W'(1);
                    if (r_inhCnt == INH_START) begin
                        r_dataOe <= 1'b1;
                    end
                    if (r_inhCnt == INH_LAST) begin
                        r_clkOe <= 1'b0;
                        r_state <= RELEASE;
                    end
                end
                default: begin
                    r_toCnt <= r_toCnt + TO_W'(1);
                    if (w_timedOut) begin
                        r_clkOe  <= 1'b0;
                        r_dataOe <= 1'b0;
                        r_done   <= 1'b1;
                        r_errTo  <= 1'b1;
                        r_ackOk  <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        case (r_state)
                            RELEASE: begin
                                if (w_fall) begin
                                    r_dataOe <= ~r_data[0];
                                    r_bitCnt <= 4'd1;
                                    r_state  <= SEND;
                                end
                            end
                            SEND: begin
                                if (w_fall) begin
                                    if (r_bitCnt < 4'd8) begin
                                        r_dataOe <= ~r_data[r_bitCnt[2:0]];
                                        r_bitCnt <= r_bitCnt + 4'd1;
                                    end else if (r_bitCnt == 4'd8) begin
                                        r_dataOe <= ~r_parity;
                                        r_bitCnt <= 4'd9;
                                    end else begin
                                        r_dataOe <= 1'b0;
                                        r_state  <= ACK;
                                    end
                                end
                            end
                            ACK: begin
                                if (w_fall) begin
                                    r_ackNext <= ~r_dataSync[1];
                                    r_state   <= WAIT_IDLE;
                                end
                            end
                            WAIT_IDLE: begin
                                if (w_clkHigh && w_dataHigh) begin
                                    r_done  <= 1'b1;
                                    r_ackOk <= r_ackNext;
                                    r_busy  <= 1'b0;
                                    r_state <= IDLE;
                                end
                            end
                            default: begin
                                r_state <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.tx_ready    = r_ready;
    assign bus.busy        = r_busy;
    assign bus.rx_inhibit  = r_busy;
    assign bus.done        = r_done;
    assign bus.ack_ok      = r_ackOk;
    assign bus.err_timeout = r_errTo;
    assign o_ps2_clk_oe    = r_clkOe;
    assign o_ps2_data_oe   = r_dataOe;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host, a scoreboard holds expected frames and completion results, and monitors
// compare what the device received and what the host reported.
module tb_ps2_host_tx;
    localparam int INHIBIT     = 50;
    localparam int TIMEOUT     = 20000;
    localparam int HALF_P      = 200;
    localparam int MODE_ACK    = 0;
    localparam int MODE_NACK   = 1;
    localparam int MODE_SILENT = 2;
    localparam int MODE_ABORT  = 3;

    typedef struct {
        logic ackOk;
        logic errTo;
    } doneExp_t;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    logic devClkLow  = 1'b0;
    logic devDataLow = 1'b0;
    logic clkOe;
    logic dataOe;
    logic lineClk;
    logic lineData;

    int       nChecks = 0;
    int       nFails  = 0;
    doneExp_t doneQ[$];
    logic [7:0] frameQ[$];
    int       devMode   = MODE_ACK;
    logic     devActive = 1'b0;
    logic     devFourth = 1'b0;
    int       cycle     = 0;
    int       busyRise  = 0;

    assign lineClk  = ~(clkOe | devClkLow);
    assign lineData = ~(dataOe | devDataLow);

    ps2_host_tx_if busIf();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .bus          (busIf),
        .i_ps2_clk    (lineClk),
        .i_ps2_data   (lineData),
        .o_ps2_clk_oe (clkOe),
        .o_ps2_data_oe(dataOe)
    );

    // 10MHz system clock keeps a 40us device clock at 400 cycles per bit.
    always #50 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int mode);
        int n;
        doneExp_t e;
        n = 0;
        while (busIf.tx_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_send", 32'(busIf.tx_ready), 1);
        devMode   = mode;
        devFourth = 1'b0;
        if (mode != MODE_ABORT) begin
            e.ackOk = (mode == MODE_ACK);
            e.errTo = (mode == MODE_SILENT);
            doneQ.push_back(e);
        end
        if (mode == MODE_ACK || mode == MODE_NACK) begin
            frameQ.push_back(data);
        end
        busIf.tx_data  = data;
        busIf.tx_valid = 1'b1;
        @(negedge clk);
        busIf.tx_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(busIf.busy), 1);
        checkOutput("rx_inhibit_after_accept", 32'(busIf.rx_inhibit), 1);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busIf.tx_ready !== 1'b1 || devActive) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("transfer_completes", 32'(n < 30000), 1);
        repeat (20) @(negedge clk);
    endtask

    // Completion monitor: every done pulse must match the oldest expected result.
    initial begin
        doneExp_t e;
        logic     prevDone;
        logic     prevBusy;
        int       oeRun;
        int       lat;
        prevDone = 1'b0;
        prevBusy = 1'b0;
        oeRun    = 0;
        forever begin
            @(negedge clk);
            cycle++;
            if (busIf.busy === 1'b1 && prevBusy !== 1'b1) begin
                busyRise = cycle;
            end
            if (clkOe === 1'b1) begin
                oeRun++;
            end else if (oeRun > 0) begin
                checkOutput("inhibit_length", 32'(oeRun), INHIBIT);
                oeRun = 0;
            end
            if (busIf.done === 1'b1) begin
                if (doneQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = doneQ.pop_front();
                    checkOutput("done_ack_ok", 32'(busIf.ack_ok), 32'(e.ackOk));
                    checkOutput("done_err_timeout", 32'(busIf.err_timeout), 32'(e.errTo));
                    checkOutput("done_bus_released", 32'({clkOe, dataOe}), 0);
                    checkOutput("done_ready_low", 32'(busIf.tx_ready), 0);
                    if (e.errTo) begin
                        lat = cycle - busyRise;
                        checkOutput("timeout_latency_ok",
                                    32'(lat >= INHIBIT + TIMEOUT - 2 && lat <= INHIBIT + TIMEOUT + 2), 1);
                    end
                end
            end else if (prevDone === 1'b1) begin
                checkOutput("err_timeout_one_cycle", 32'(busIf.err_timeout), 0);
                checkOutput("ready_after_done", 32'(busIf.tx_ready), 1);
            end
            prevDone = busIf.done;
            prevBusy = busIf.busy;
        end
    end

    // Device model: waits for request-to-send, clocks 11 edges, reads the frame and ACKs or NACKs.
    initial begin
        logic [9:0] bits;
        logic [7:0] expByte;
        int         mode;
        logic       aborted;
        bits = '0;
        forever begin
            while (lineClk !== 1'b0) @(negedge clk);
            while (!(lineClk === 1'b1 && lineData === 1'b0)) @(negedge clk);
            mode      = devMode;
            devActive = 1'b1;
            aborted   = 1'b0;
            if (mode == MODE_SILENT) begin
                while (lineData !== 1'b1) @(negedge clk);
            end else begin
                repeat (HALF_P) @(negedge clk);
                for (int e = 1; e <= 11; e++) begin
                    devClkLow = 1'b1;
                    if (mode == MODE_ABORT && e == 4) begin
                        devFourth = 1'b1;
                        repeat (HALF_P) @(negedge clk);
                        devClkLow = 1'b0;
                        aborted   = 1'b1;
                        break;
                    end
                    repeat (HALF_P) @(negedge clk);
                    if (e <= 10) begin
                        bits[e-1] = lineData;
                    end
                    devClkLow = 1'b0;
                    if (e == 10 && mode == MODE_ACK) begin
                        devDataLow = 1'b1;
                    end
                    if (e == 11) begin
                        devDataLow = 1'b0;
                    end
                    repeat (HALF_P) @(negedge clk);
                end
                if (!aborted) begin
                    if (frameQ.size() == 0) begin
                        checkOutput("unexpected_frame", 1, 0);
                    end else begin
                        expByte = frameQ.pop_front();
                        checkOutput("frame_byte", 32'(bits[7:0]), 32'(expByte));
                        checkOutput("frame_parity", 32'(bits[8]),
                                    ($countones(expByte) % 2 == 0) ? 32'd1 : 32'd0);
                        checkOutput("frame_stop", 32'(bits[9]), 1);
                    end
                end
            end
            devClkLow  = 1'b0;
            devDataLow = 1'b0;
            devActive  = 1'b0;
        end
    end

    // Directed scenarios followed by a few randomized transfers.
    initial begin
        int         n;
        logic [7:0] rnd;
        busIf.tx_valid = 1'b0;
        busIf.tx_data  = 8'h00;
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state",
                    32'({busIf.tx_ready, busIf.busy, busIf.rx_inhibit, busIf.done,
                         busIf.ack_ok, busIf.err_timeout, clkOe, dataOe}), 32'h80);
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        applyStimulus(8'hED, MODE_ACK);
        waitIdle();
        checkOutput("ack_ok_holds", 32'(busIf.ack_ok), 1);

        applyStimulus(8'hFF, MODE_ACK);
        waitIdle();

        rnd = 8'($urandom_range(0, 255));
        applyStimulus(rnd, MODE_NACK);
        waitIdle();
        checkOutput("nack_ack_ok", 32'(busIf.ack_ok), 0);

        rnd = 8'($urandom_range(0, 255));
        applyStimulus(rnd, MODE_SILENT);
        waitIdle();

        applyStimulus(8'hED, MODE_ACK);
        repeat (100) @(negedge clk);
        checkOutput("ready_low_while_busy", 32'(busIf.tx_ready), 0);
        busIf.tx_data  = 8'h55;
        busIf.tx_valid = 1'b1;
        @(negedge clk);
        busIf.tx_valid = 1'b0;
        waitIdle();

        rnd = 8'($urandom_range(0, 255));
        applyStimulus(rnd, MODE_ABORT);
        n = 0;
        while (devFourth !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("fourth_edge_reached", 32'(n < 20000), 1);
        repeat (5) @(negedge clk);
        #3 clrn = 1'b0;
        #1 checkOutput("reset_midframe",
                       32'({clkOe, dataOe, busIf.tx_ready, busIf.busy}), 32'b0010);
        repeat (10) @(negedge clk);
        clrn = 1'b1;
        waitIdle();

        applyStimulus(8'hF4, MODE_ACK);
        waitIdle();

        for (int i = 0; i < 3; i++) begin
            rnd = 8'($urandom_range(0, 255));
            applyStimulus(rnd, ($urandom_range(0, 1) == 0) ? MODE_ACK : MODE_NACK);
            waitIdle();
        end

        checkOutput("done_queue_empty", 32'(doneQ.size()), 0);
        checkOutput("frame_queue_empty", 32'(frameQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
